spi_slave_dx: RTL and testbench

- Full-duplex SPI slave (target) for the multi-protocol module; it is the far end of the existing SPI master path.
- Samples an external SCLK/CS_N/MOSI domain with the system clock, supports all four SPI modes, and shifts out a preloaded byte on MISO while capturing MOSI.
- Reports each received byte with a one-cycle done strobe.
- Used both on-chip as the loopback target and for driving real external masters.

---
 rtl/spi_slave_dx_if.sv | 34 +++
 rtl/spi_slave_dx.sv | 179 +++++++++++++++++
 tb/tb_spi_slave_dx.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_dx_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_dx_if
// Brief    : Pin and parallel-side bundle of the SPI target.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_slave_dx_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        spi_mode;
    logic              load;
    logic [DATA_W-1:0] p_dat;
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] rcvd_dat;
    logic              sdone;
    logic              busy;
    logic              tx_ovr;
    logic              rx_err;

    modport slave (
        input  spi_mode, load, p_dat, sclk, cs_n, mosi,
        output miso, miso_oe, rcvd_dat, sdone, busy, tx_ovr, rx_err
    );

    modport master (
        output spi_mode, load, p_dat, sclk, cs_n, mosi,
        input  miso, miso_oe, rcvd_dat, sdone, busy, tx_ovr, rx_err
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_dx.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_dx
// Brief    : Full-duplex SPI target, all four modes, oversampled by clk.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_dx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    spi_slave_dx_if.slave bus
);

    localparam int                 c_CNT_W     = $clog2(DATA_W) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);
    localparam logic [0:0]         c_ST_IDLE   = 1'b0;
    localparam logic [0:0]         c_ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    logic                   w_sclk;
    logic                   w_cs_n;
    logic                   w_mosi;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_cs_fall;

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic                   w_active;

    logic [1:0]             r_mode;
    logic [DATA_W-1:0]      r_tx_buf;
    logic [DATA_W-1:0]      r_tx_shift;
    logic [DATA_W-2:0]      r_rx_shift;
    logic [DATA_W-1:0]      w_rx_next;
    logic [DATA_W-1:0]      r_rcvd;
    logic [c_CNT_W-1:0]     r_cnt;

    logic                   w_sample;
    logic                   w_shift;
    logic                   w_complete;

    logic                   r_sdone;
    logic                   r_rx_err;
    logic                   r_tx_ovr;
    logic                   w_busy;
    logic                   w_miso_oe;
    logic                   w_miso;

    // Sync flops clear to 0 so a cs_n already low when reset releases is not
    // mistaken for a fresh select; the master must deselect first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n    = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise    = w_sclk & ~r_sclk_prev;
    assign w_fall    = ~w_sclk & r_sclk_prev;
    assign w_cs_fall = ~w_cs_n & r_cs_prev;
    assign w_active  = (r_state == c_ST_ACTIVE);

    // Modes 0 and 3 (CPOL == CPHA) sample on rising sclk, modes 1 and 2 on falling.
    assign w_sample   = w_active & ((r_mode[1] == r_mode[0]) ? w_rise : w_fall);
    assign w_shift    = w_active & ((r_mode[1] == r_mode[0]) ? w_fall : w_rise);
    assign w_rx_next  = {r_rx_shift, w_mosi};
    assign w_complete = w_sample & (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_cs_fall) w_state_nxt = c_ST_ACTIVE;
            c_ST_ACTIVE: if (w_cs_n)    w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = 1'b0;
        w_miso_oe = 1'b0;
        w_miso    = 1'b0;
        if (r_state == c_ST_ACTIVE) begin
            w_busy    = 1'b1;
            w_miso_oe = 1'b1;
            w_miso    = r_tx_shift[DATA_W-1];
        end
    end

    // Shift edges only advance tx_shift once a bit has been sampled in the
    // current frame: this skips the CPHA=1 leading edge and the CPHA=0
    // trailing edge that follows a completed frame and its reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= 2'b00;
            r_tx_buf   <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rcvd     <= '0;
            r_cnt      <= '0;
            r_sdone    <= 1'b0;
            r_rx_err   <= 1'b0;
            r_tx_ovr   <= 1'b0;
        end else begin
            r_sdone  <= 1'b0;
            r_rx_err <= 1'b0;
            r_tx_ovr <= bus.load & w_active;
            if (!w_active) begin
                if (bus.load) begin
                    r_tx_buf <= bus.p_dat;
                end
                if (w_cs_fall) begin
                    r_mode     <= bus.spi_mode;
                    r_tx_shift <= r_tx_buf;
                    r_rx_shift <= '0;
                    r_cnt      <= '0;
                end
            end else if (w_cs_n) begin
                if (w_complete) begin
                    r_rcvd  <= w_rx_next;
                    r_sdone <= 1'b1;
                end else if ((r_cnt != '0) || w_sample) begin
                    r_rx_err <= 1'b1;
                end
                r_cnt <= '0;
            end else if (w_sample) begin
                if (w_complete) begin
                    r_rcvd     <= w_rx_next;
                    r_sdone    <= 1'b1;
                    r_cnt      <= '0;
                    r_tx_shift <= r_tx_buf;
                end else begin
                    r_rx_shift <= w_rx_next[DATA_W-2:0];
                    r_cnt      <= r_cnt + c_ONE;
                end
            end else if (w_shift && (r_cnt != '0)) begin
                r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign bus.miso     = w_miso;
    assign bus.miso_oe  = w_miso_oe;
    assign bus.busy     = w_busy;
    assign bus.rcvd_dat = r_rcvd;
    assign bus.sdone    = r_sdone;
    assign bus.rx_err   = r_rx_err;
    assign bus.tx_ovr   = r_tx_ovr;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_dx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_dx
// Brief    : Bit-banging SPI master with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_dx;

    localparam int c_DW   = 8;
    localparam int c_SYNC = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_dx_if #(.DATA_W(c_DW)) bus ();

    spi_slave_dx #(.DATA_W(c_DW), .SYNC_STAGES(c_SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int              n_checks = 0;
    int              n_err    = 0;
    int              n_sdone  = 0;
    int              n_rxerr  = 0;
    int              n_ovr    = 0;
    logic [c_DW-1:0] exp_q[$];
    logic [c_DW-1:0] mosi_q[$];
    bit              mrx_bits[$];
    logic [c_DW-1:0] exp_txbuf = '0;
    logic [c_DW-1:0] exp_rcvd  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic mbit(input int b);
        logic [c_DW-1:0] v;
        v = (b / c_DW < mosi_q.size()) ? mosi_q[b / c_DW] : '0;
        return v[c_DW-1-(b % c_DW)];
    endfunction

    function automatic logic [c_DW-1:0] mrx_byte(input int k);
        logic [c_DW-1:0] v;
        v = '0;
        for (int i = 0; i < c_DW; i++) v = {v[c_DW-2:0], mrx_bits[k*c_DW+i]};
        return v;
    endfunction

    // Frame-level model: selected long enough => busy; deselected long enough
    // => idle outputs; each sdone pops the next expected byte; rcvd holds otherwise.
    int              sel_age = -1;
    int              hi_age  = -1;
    logic            prev_cs = 1'b0;
    logic [c_DW-1:0] prev_rcvd = '0;
    always @(negedge clk) begin
        if (rst) begin
            sel_age   = -1;
            hi_age    = -1;
            prev_cs   = 1'b0;
            prev_rcvd = bus.rcvd_dat;
        end else begin
            if (bus.cs_n) begin
                sel_age = -1;
                hi_age  = (hi_age < 0) ? 0 : hi_age + 1;
            end else begin
                hi_age = -1;
                if (sel_age >= 0) sel_age++;
                else if (prev_cs) sel_age = 0;
            end
            prev_cs = bus.cs_n;
            if (sel_age > c_SYNC + 2) chk("selected", {bus.busy, bus.miso_oe}, 2'b11);
            if (hi_age > c_SYNC + 2)  chk("deselected", {bus.busy, bus.miso_oe, bus.miso}, 3'b000);
            if (bus.sdone) begin
                n_sdone++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL sdone_unexpected: rcvd_dat=%0h, no frame pending", bus.rcvd_dat);
                end else begin
                    chk("rcvd_dat", bus.rcvd_dat, exp_q.pop_front());
                end
                chk("sdone_with_rx_err", bus.rx_err, 1'b0);
            end else begin
                chk("rcvd_hold", bus.rcvd_dat, prev_rcvd);
            end
            if (bus.rx_err) n_rxerr++;
            if (bus.tx_ovr) n_ovr++;
            prev_rcvd = bus.rcvd_dat;
        end
    end

    task automatic xfer(input logic [1:0] mode, input int nbits, input int h);
        mrx_bits.delete();
        bus.spi_mode = mode;
        bus.sclk     = mode[1];
        repeat (h) @(negedge clk);
        bus.cs_n = 1'b0;
        if (!mode[0]) bus.mosi = mbit(0);
        for (int b = 0; b < nbits; b++) begin
            repeat (h) @(negedge clk);
            bus.sclk = ~mode[1];
            if (mode[0]) bus.mosi = mbit(b);
            else         mrx_bits.push_back(bus.miso);
            repeat (h) @(negedge clk);
            bus.sclk = mode[1];
            if (mode[0])           mrx_bits.push_back(bus.miso);
            else if (b + 1 < nbits) bus.mosi = mbit(b + 1);
        end
        repeat (h) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (c_SYNC + 6) @(negedge clk);
    endtask

    task automatic do_load(input logic [c_DW-1:0] v);
        bus.load  = 1'b1;
        bus.p_dat = v;
        @(negedge clk);
        bus.load  = 1'b0;
        exp_txbuf = v;
    endtask

    task automatic run_frames(input logic [1:0] mode, input int nf, input int part, input int h);
        int              e0;
        logic [c_DW-1:0] pb;
        e0 = n_rxerr;
        for (int k = 0; k < nf; k++) exp_q.push_back(mosi_q[k]);
        xfer(mode, nf * c_DW + part, h);
        chk("sdone_missing", exp_q.size(), 0);
        exp_q.delete();
        chk("rx_err_count", n_rxerr - e0, (part != 0) ? 1 : 0);
        for (int k = 0; k < nf; k++) chk("master_rx", mrx_byte(k), exp_txbuf);
        if (part != 0) begin
            pb = '0;
            for (int i = 0; i < part; i++) pb = {pb[c_DW-2:0], mrx_bits[nf*c_DW+i]};
            chk("master_rx_partial", pb, exp_txbuf >> (c_DW - part));
        end
        if (nf > 0) exp_rcvd = mosi_q[nf-1];
        chk("rcvd_final", bus.rcvd_dat, exp_rcvd);
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish within 200000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, o0, e0, m, nf, part, h;
        rst = 1'b1;
        bus.spi_mode = 2'b00;
        bus.load     = 1'b0;
        bus.p_dat    = '0;
        bus.sclk     = 1'b0;
        bus.cs_n     = 1'b1;
        bus.mosi     = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_state", {bus.miso, bus.miso_oe, bus.rcvd_dat, bus.sdone, bus.busy,
                            bus.tx_ovr, bus.rx_err}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Mode 0: 0x55 out, 0xA3 in
        do_load(8'h55);
        mosi_q = '{8'hA3};
        s0 = n_sdone;
        run_frames(2'b00, 1, 0, 6);
        chk("m0_master_lit", mrx_byte(0), 8'h55);
        chk("m0_rcvd_lit", bus.rcvd_dat, 8'hA3);
        chk("m0_sdone_once", n_sdone - s0, 1);

        // Modes 2, 1, 3: 0x42 out, 0x3C in
        do_load(8'h42);
        for (int i = 0; i < 3; i++) begin
            mosi_q = '{8'h3C};
            run_frames((i == 0) ? 2'b10 : (i == 1) ? 2'b01 : 2'b11, 1, 0, 5);
            chk("mx_master_lit", mrx_byte(0), 8'h42);
            chk("mx_rcvd_lit", bus.rcvd_dat, 8'h3C);
        end

        // Back-to-back frames under one select
        do_load(8'h7E);
        mosi_q = '{8'h11, 8'h22};
        s0 = n_sdone;
        run_frames(2'b00, 2, 0, 6);
        chk("b2b_sdone_twice", n_sdone - s0, 2);
        chk("b2b_master1_lit", mrx_byte(1), 8'h7E);
        chk("b2b_rcvd_lit", bus.rcvd_dat, 8'h22);

        // Deselect after 4 bits
        mosi_q = '{8'hF0};
        s0 = n_sdone;
        e0 = n_rxerr;
        run_frames(2'b00, 0, 4, 6);
        chk("abort_rx_err_lit", n_rxerr - e0, 1);
        chk("abort_no_sdone", n_sdone - s0, 0);
        chk("abort_rcvd_kept_lit", bus.rcvd_dat, 8'h22);

        // Load and mode change while busy are ignored
        do_load(8'h0F);
        mosi_q = '{8'h5A};
        exp_q.push_back(8'h5A);
        o0 = n_ovr;
        fork
            xfer(2'b00, 8, 6);
            begin
                repeat (40) @(negedge clk);
                bus.load     = 1'b1;
                bus.p_dat    = 8'hFF;
                bus.spi_mode = 2'b11;
                repeat (3) @(negedge clk);
                bus.load     = 1'b0;
            end
        join
        exp_rcvd = 8'h5A;
        chk("ovr_pulses", n_ovr - o0, 3);
        chk("ovr_master_lit", mrx_byte(0), 8'h0F);
        chk("ovr_rcvd", bus.rcvd_dat, 8'h5A);
        chk("ovr_sdone_missing", exp_q.size(), 0);
        exp_q.delete();
        mosi_q = '{8'h96};
        run_frames(2'b00, 1, 0, 5);
        chk("ovr_next_master_lit", mrx_byte(0), 8'h0F);

        // Reset after 5 bits aborts silently
        mosi_q = '{8'h99};
        s0 = n_sdone;
        e0 = n_rxerr;
        fork
            xfer(2'b00, 8, 6);
            begin
                repeat (6 + 5 * 12 + 3) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                chk("rst_midframe_outputs", {bus.miso, bus.miso_oe, bus.rcvd_dat, bus.sdone,
                                             bus.busy, bus.tx_ovr, bus.rx_err}, 0);
                @(negedge clk);
                rst = 1'b0;
            end
        join
        exp_txbuf = '0;
        exp_rcvd  = '0;
        chk("rst_no_rx_err", n_rxerr - e0, 0);
        chk("rst_no_sdone", n_sdone - s0, 0);
        mosi_q = '{8'hC6};
        run_frames(2'b00, 1, 0, 6);
        chk("rst_next_rcvd_lit", bus.rcvd_dat, 8'hC6);
        chk("rst_next_master_lit", mrx_byte(0), 8'h00);

        // Randomised frames against the model
        for (int it = 0; it < 24; it++) begin
            m    = $urandom_range(0, 3);
            nf   = $urandom_range(0, 3);
            part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, c_DW - 1) : 0;
            if (nf == 0 && part == 0) nf = 1;
            h    = $urandom_range(c_SYNC + 2, 8);
            if ($urandom_range(0, 1) == 1) do_load(8'($urandom));
            mosi_q.delete();
            for (int k = 0; k <= nf; k++) mosi_q.push_back(8'($urandom));
            run_frames(2'(m), nf, part, h);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
